// File: rtl/ctrl_pkg.sv
// Shared control definitions for the ID/EX control pipeline: RV32I opcodes,
// ALU operation encodings and the decoded control bundle.
package ctrl_pkg;

    localparam logic [6:0] OpcR      = 7'b0110011;
    localparam logic [6:0] OpcImm    = 7'b0010011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;

    localparam logic [6:0] Funct7Base = 7'b0000000;
    localparam logic [6:0] Funct7Alt  = 7'b0100000;

    localparam int unsigned AluOpW = 4;

    typedef enum logic [AluOpW-1:0] {
        AluAdd   = 4'd0,
        AluSub   = 4'd1,
        AluSll   = 4'd2,
        AluSlt   = 4'd3,
        AluSltu  = 4'd4,
        AluXor   = 4'd5,
        AluSrl   = 4'd6,
        AluSra   = 4'd7,
        AluOr    = 4'd8,
        AluAnd   = 4'd9,
        AluPassB = 4'd10
    } alu_op_e;

    typedef struct packed {
        logic    reg_write;
        logic    alu_src;
        logic    alu_src_a_pc;
        logic    mem_read;
        logic    mem_write;
        logic    mem_to_reg;
        logic    branch;
        logic    jump;
        alu_op_e alu_ctrl;
    } ctrl_t;

    // alt selects the SUB/SRA variant; only funct3 000 and 101 have one.
    function automatic alu_op_e alu_from_funct3(input logic [2:0] funct3, input logic alt);
        alu_op_e op;
        case (funct3)
            3'b000:  op = alt ? AluSub : AluAdd;
            3'b001:  op = AluSll;
            3'b010:  op = AluSlt;
            3'b011:  op = AluSltu;
            3'b100:  op = AluXor;
            3'b101:  op = alt ? AluSra : AluSrl;
            3'b110:  op = AluOr;
            default: op = AluAnd;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational RV32I control decoder: instruction -> control bundle, register
// fields and source-register usage. CTRL_ILLEGAL_TRAP_EN adds the illegal flag.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output ctrl_t       ctrl,
    output logic [2:0]  funct3,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic        uses_rs1,
    output logic        uses_rs2
`ifdef CTRL_ILLEGAL_TRAP_EN
    ,
    output logic        illegal
`endif
);

    logic [6:0] opcode;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign rd     = instr[11:7];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic [6:0] funct7;
    logic       known_opcode;

    assign funct7       = instr[31:25];
    assign known_opcode = opcode inside {OpcR, OpcImm, OpcLoad, OpcStore, OpcBranch,
                                         OpcJal, OpcJalr, OpcLui, OpcAuipc};
    assign illegal      = !known_opcode ||
                          (opcode == OpcR && funct7 != Funct7Base && funct7 != Funct7Alt);
`else
    logic unused_funct7_bits;
    assign unused_funct7_bits = ^{instr[31], instr[29:25]};
`endif

    always_comb begin
        ctrl     = ctrl_t'('0);
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (opcode)
            OpcR: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_ctrl  = alu_from_funct3(funct3, instr[30]);
                uses_rs1       = 1'b1;
                uses_rs2       = 1'b1;
            end
            OpcImm: begin
                // bit 30 is immediate data except for SRAI
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_ctrl  = alu_from_funct3(funct3, instr[30] && funct3 == 3'b101);
                uses_rs1       = 1'b1;
            end
            OpcLoad: begin
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                uses_rs1        = 1'b1;
            end
            OpcStore: begin
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
                uses_rs1       = 1'b1;
                uses_rs2       = 1'b1;
            end
            OpcBranch: begin
                ctrl.branch   = 1'b1;
                ctrl.alu_ctrl = funct3[2] ? (funct3[1] ? AluSltu : AluSlt) : AluSub;
                uses_rs1      = 1'b1;
                uses_rs2      = 1'b1;
            end
            OpcJal: begin
                ctrl.reg_write = 1'b1;
                ctrl.jump      = 1'b1;
            end
            OpcJalr: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.jump      = 1'b1;
                uses_rs1       = 1'b1;
            end
            OpcLui: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_ctrl  = AluPassB;
            end
            OpcAuipc: begin
                ctrl.reg_write    = 1'b1;
                ctrl.alu_src      = 1'b1;
                ctrl.alu_src_a_pc = 1'b1;
            end
            default: ;
        endcase
`ifdef CTRL_ILLEGAL_TRAP_EN
        if (illegal) begin
            ctrl = ctrl_t'('0);
        end
`endif
        if (rd == 5'd0) begin
            ctrl.reg_write = 1'b0;
        end
    end

endmodule

// File: rtl/id_ex_ctrl_pipe.sv
// ID/EX control pipeline register with RV32I decode and load-use bubble insertion.
// Build option: CTRL_ILLEGAL_TRAP_EN adds ex_illegal and traps unknown encodings.
module id_ex_ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int unsigned ALU_CTRL_W       = 4,
    parameter int unsigned REG_ADDR_W       = 5,
    parameter int unsigned LOAD_USE_BUBBLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [31:0]           id_instr,
    output logic                  id_ready,
    input  logic                  ex_hold,
    input  logic                  ex_flush,
    output logic                  ex_valid,
    output logic                  ex_reg_write,
    output logic                  ex_alu_src,
    output logic                  ex_alu_src_a_pc,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic                  ex_mem_to_reg,
    output logic                  ex_branch,
    output logic                  ex_jump,
    output logic [ALU_CTRL_W-1:0] ex_alu_ctrl,
    output logic [2:0]            ex_funct3,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic [REG_ADDR_W-1:0] ex_rs1,
    output logic [REG_ADDR_W-1:0] ex_rs2
`ifdef CTRL_ILLEGAL_TRAP_EN
    ,
    output logic                  ex_illegal
`endif
);

    localparam int unsigned CntW = 2;

    typedef enum logic [0:0] {StRun, StStall} state_e;

    ctrl_t      dec_ctrl;
    logic [2:0] dec_funct3;
    logic [4:0] dec_rd;
    logic [4:0] dec_rs1;
    logic [4:0] dec_rs2;
    logic       uses_rs1;
    logic       uses_rs2;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic       dec_illegal;
`endif

    ctrl_decode u_decode (
        .instr    (id_instr),
        .ctrl     (dec_ctrl),
        .funct3   (dec_funct3),
        .rd       (dec_rd),
        .rs1      (dec_rs1),
        .rs2      (dec_rs2),
        .uses_rs1 (uses_rs1),
        .uses_rs2 (uses_rs2)
`ifdef CTRL_ILLEGAL_TRAP_EN
        ,
        .illegal  (dec_illegal)
`endif
    );

    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  ex_valid_q, ex_valid_d;
    ctrl_t                 ex_ctrl_q, ex_ctrl_d;
    logic [2:0]            ex_funct3_q, ex_funct3_d;
    logic [REG_ADDR_W-1:0] ex_rd_q, ex_rd_d;
    logic [REG_ADDR_W-1:0] ex_rs1_q, ex_rs1_d;
    logic [REG_ADDR_W-1:0] ex_rs2_q, ex_rs2_d;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic                  ex_illegal_q, ex_illegal_d;
`endif

    logic hazard;
    logic accept;
    logic load_bubble;
    logic ready_c;

    // A load in EX whose result is a source of the ID instruction.
    always_comb begin
        hazard = ex_valid_q && ex_ctrl_q.mem_read && (ex_rd_q != '0) && id_valid &&
                 ((uses_rs1 && (REG_ADDR_W'(dec_rs1) == ex_rd_q)) ||
                  (uses_rs2 && (REG_ADDR_W'(dec_rs2) == ex_rd_q)));
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ready_c     = 1'b0;
        accept      = 1'b0;
        load_bubble = 1'b0;
        if (ex_flush) begin
            // Wrong-path ID instruction is consumed and discarded.
            load_bubble = 1'b1;
            state_d     = StRun;
            cnt_d       = '0;
            ready_c     = 1'b1;
        end else if (!ex_hold) begin
            unique case (state_q)
                StRun: begin
                    if (hazard) begin
                        load_bubble = 1'b1;
                        cnt_d       = CntW'(LOAD_USE_BUBBLES - 1);
                        if (cnt_d != '0) begin
                            state_d = StStall;
                        end
                    end else begin
                        ready_c     = 1'b1;
                        accept      = id_valid;
                        load_bubble = !id_valid;
                    end
                end
                StStall: begin
                    load_bubble = 1'b1;
                    cnt_d       = cnt_q - 1'b1;
                    if (cnt_d == '0) begin
                        state_d = StRun;
                    end
                end
            endcase
        end
    end

    always_comb begin
        ex_valid_d  = ex_valid_q;
        ex_ctrl_d   = ex_ctrl_q;
        ex_funct3_d = ex_funct3_q;
        ex_rd_d     = ex_rd_q;
        ex_rs1_d    = ex_rs1_q;
        ex_rs2_d    = ex_rs2_q;
`ifdef CTRL_ILLEGAL_TRAP_EN
        ex_illegal_d = ex_illegal_q;
`endif
        if (load_bubble) begin
            ex_valid_d  = 1'b0;
            ex_ctrl_d   = ctrl_t'('0);
            ex_funct3_d = '0;
            ex_rd_d     = '0;
            ex_rs1_d    = '0;
            ex_rs2_d    = '0;
`ifdef CTRL_ILLEGAL_TRAP_EN
            ex_illegal_d = 1'b0;
`endif
        end else if (accept) begin
            ex_valid_d  = 1'b1;
            ex_ctrl_d   = dec_ctrl;
            ex_funct3_d = dec_funct3;
            ex_rd_d     = REG_ADDR_W'(dec_rd);
            ex_rs1_d    = REG_ADDR_W'(dec_rs1);
            ex_rs2_d    = REG_ADDR_W'(dec_rs2);
`ifdef CTRL_ILLEGAL_TRAP_EN
            ex_illegal_d = dec_illegal;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StRun;
            cnt_q       <= '0;
            ex_valid_q  <= 1'b0;
            ex_ctrl_q   <= ctrl_t'('0);
            ex_funct3_q <= '0;
            ex_rd_q     <= '0;
            ex_rs1_q    <= '0;
            ex_rs2_q    <= '0;
`ifdef CTRL_ILLEGAL_TRAP_EN
            ex_illegal_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ex_valid_q  <= ex_valid_d;
            ex_ctrl_q   <= ex_ctrl_d;
            ex_funct3_q <= ex_funct3_d;
            ex_rd_q     <= ex_rd_d;
            ex_rs1_q    <= ex_rs1_d;
            ex_rs2_q    <= ex_rs2_d;
`ifdef CTRL_ILLEGAL_TRAP_EN
            ex_illegal_q <= ex_illegal_d;
`endif
        end
    end

    assign id_ready        = ready_c && !rst;
    assign ex_valid        = ex_valid_q;
    assign ex_reg_write    = ex_ctrl_q.reg_write;
    assign ex_alu_src      = ex_ctrl_q.alu_src;
    assign ex_alu_src_a_pc = ex_ctrl_q.alu_src_a_pc;
    assign ex_mem_read     = ex_ctrl_q.mem_read;
    assign ex_mem_write    = ex_ctrl_q.mem_write;
    assign ex_mem_to_reg   = ex_ctrl_q.mem_to_reg;
    assign ex_branch       = ex_ctrl_q.branch;
    assign ex_jump         = ex_ctrl_q.jump;
    assign ex_alu_ctrl     = ALU_CTRL_W'(ex_ctrl_q.alu_ctrl);
    assign ex_funct3       = ex_funct3_q;
    assign ex_rd           = ex_rd_q;
    assign ex_rs1          = ex_rs1_q;
    assign ex_rs2          = ex_rs2_q;
`ifdef CTRL_ILLEGAL_TRAP_EN
    assign ex_illegal      = ex_illegal_q;
`endif

endmodule

// File: tb/tb_id_ex_ctrl_pipe.sv
// Bench for id_ex_ctrl_pipe: two instances (1 and 2 load-use bubbles) share stimulus and
// are compared each cycle against an instruction-level reference model.
module tb_id_ex_ctrl_pipe;

    typedef struct packed {
        logic       v, rw, asrc, apc, mr, mw, m2r, br, jmp;
        logic [3:0] alu;
        logic [2:0] f3;
        logic [4:0] rd, rs1, rs2;
        logic       ill;
    } exp_t;

    localparam logic [31:0] InsAdd   = 32'h002081B3;  // add x3,x1,x2
    localparam logic [31:0] InsSub   = 32'h402081B3;  // sub x3,x1,x2
    localparam logic [31:0] InsLw5   = 32'h0000A283;  // lw  x5,0(x1)
    localparam logic [31:0] InsAdd6  = 32'h00228333;  // add x6,x5,x2
    localparam logic [31:0] InsLw0   = 32'h0000A003;  // lw  x0,0(x1)
    localparam logic [31:0] InsAdd60 = 32'h00200333;  // add x6,x0,x2
    localparam logic [31:0] InsUnk   = 32'h000002FF;  // opcode 7F, rd x5

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid = 1'b0;
    logic [31:0] id_instr = '0;
    logic        ex_hold = 1'b0;
    logic        ex_flush = 1'b0;

    logic [31:0] act [2];
    logic        rdy [2];

    int n_tests = 0;
    int n_fail  = 0;

    exp_t mdl [2];
    exp_t pend [2];
    int   left [2];
    int   pleft [2];
    bit   mready [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic       ready, v, rw, asrc, apc, mr, mw, m2r, br, jmp, ill;
        logic [3:0] alu;
        logic [2:0] f3;
        logic [4:0] rd, rs1, rs2;

        id_ex_ctrl_pipe #(
            .ALU_CTRL_W       (4),
            .REG_ADDR_W       (5),
            .LOAD_USE_BUBBLES (g + 1)
        ) u_dut (
            .clk             (clk),
            .rst             (rst),
            .id_valid        (id_valid),
            .id_instr        (id_instr),
            .id_ready        (ready),
            .ex_hold         (ex_hold),
            .ex_flush        (ex_flush),
            .ex_valid        (v),
            .ex_reg_write    (rw),
            .ex_alu_src      (asrc),
            .ex_alu_src_a_pc (apc),
            .ex_mem_read     (mr),
            .ex_mem_write    (mw),
            .ex_mem_to_reg   (m2r),
            .ex_branch       (br),
            .ex_jump         (jmp),
            .ex_alu_ctrl     (alu),
            .ex_funct3       (f3),
            .ex_rd           (rd),
            .ex_rs1          (rs1),
            .ex_rs2          (rs2)
`ifdef CTRL_ILLEGAL_TRAP_EN
            ,
            .ex_illegal      (ill)
`endif
        );
`ifndef CTRL_ILLEGAL_TRAP_EN
        assign ill = 1'b0;
`endif
        assign act[g] = {v, rw, asrc, apc, mr, mw, m2r, br, jmp, alu, f3, rd, rs1, rs2, ill};
        assign rdy[g] = ready;
    end

    // ---------------- reference model ----------------
    function automatic logic [3:0] m_alu(input logic [2:0] f3, input bit alt);
        logic [3:0] tbl [8];
        tbl = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
        if (alt && f3 == 3'd0) return 4'd1;
        if (alt && f3 == 3'd5) return 4'd7;
        return tbl[f3];
    endfunction

    function automatic exp_t m_decode(input logic [31:0] ins);
        exp_t       e;
        logic [6:0] op, f7;
        logic [2:0] f3;
        op = ins[6:0];
        f3 = ins[14:12];
        f7 = ins[31:25];
        e = '0;
        e.v = 1'b1;
        e.f3 = f3;
        e.rd = ins[11:7];
        e.rs1 = ins[19:15];
        e.rs2 = ins[24:20];
        case (op)
            7'h33: begin e.rw = 1'b1; e.alu = m_alu(f3, ins[30]); end
            7'h13: begin e.rw = 1'b1; e.asrc = 1'b1; e.alu = m_alu(f3, ins[30] && f3 == 3'd5); end
            7'h03: {e.rw, e.asrc, e.mr, e.m2r} = 4'hF;
            7'h23: {e.asrc, e.mw} = 2'b11;
            7'h63: begin e.br = 1'b1; e.alu = (f3 < 3'd4) ? 4'd1 : (f3 >= 3'd6) ? 4'd4 : 4'd3; end
            7'h6F: {e.rw, e.jmp} = 2'b11;
            7'h67: {e.rw, e.asrc, e.jmp} = 3'b111;
            7'h37: begin {e.rw, e.asrc} = 2'b11; e.alu = 4'd10; end
            7'h17: {e.rw, e.asrc, e.apc} = 3'b111;
            default: e.ill = 1'b1;
        endcase
        if (op == 7'h33 && !(f7 inside {7'h00, 7'h20})) e.ill = 1'b1;
`ifdef CTRL_ILLEGAL_TRAP_EN
        if (e.ill) begin
            {e.rw, e.asrc, e.apc, e.mr, e.mw, e.m2r, e.br, e.jmp} = '0;
            e.alu = '0;
        end
`else
        e.ill = 1'b0;
`endif
        if (e.rd == 5'd0) e.rw = 1'b0;
        return e;
    endfunction

    // Next EX contents and id_ready for the current inputs; committed at the edge.
    task automatic model_eval();
        for (int k = 0; k < 2; k++) begin
            exp_t       e;
            bit         haz, u1, u2;
            logic [6:0] op;
            e  = mdl[k];
            op = id_instr[6:0];
            u1 = op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67};
            u2 = op inside {7'h33, 7'h23, 7'h63};
            haz = e.v && e.mr && e.rd != 0 && id_valid &&
                  ((u1 && id_instr[19:15] == e.rd) || (u2 && id_instr[24:20] == e.rd));
            if (rst) begin
                mready[k] = 1'b0; pend[k] = '0; pleft[k] = 0;
            end else if (ex_flush) begin
                mready[k] = 1'b1; pend[k] = '0; pleft[k] = 0;
            end else if (ex_hold) begin
                mready[k] = 1'b0; pend[k] = e; pleft[k] = left[k];
            end else if (left[k] > 0) begin
                mready[k] = 1'b0; pend[k] = '0; pleft[k] = left[k] - 1;
            end else if (haz) begin
                mready[k] = 1'b0; pend[k] = '0; pleft[k] = k;  // instance k inserts k+1 bubbles
            end else begin
                mready[k] = 1'b1; pend[k] = id_valid ? m_decode(id_instr) : '0; pleft[k] = 0;
            end
        end
    endtask

    task automatic drive(input bit v, input logic [31:0] ins, input bit h, input bit f);
        id_valid = v;
        id_instr = ins;
        ex_hold  = h;
        ex_flush = f;
        #1;
        model_eval();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            mdl[k]  = pend[k];
            left[k] = pleft[k];
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [10];
        logic [6:0] op, f7;
        logic [2:0] f3;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F};
        op = ops[$urandom_range(0, 9)];
        f3 = 3'($urandom_range(0, 7));
        if (op == 7'h63 && f3[2:1] == 2'b01) f3 = 3'b000;
        f7 = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        if ($urandom_range(0, 15) == 0) f7 = 7'h01;
        return {f7, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), f3,
                5'($urandom_range(0, 3)), op};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        drive(1'b1, InsAdd, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (rdy[k] !== 1'b0) begin
                n_fail++; $display("FAIL reset.id_ready[%0d] got %b want 0", k, rdy[k]);
            end
        end
        tick();
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (act[k] !== 32'h0 || act[k] !== mdl[k]) begin
                n_fail++; $display("FAIL reset.outputs[%0d] got %h want 0", k, act[k]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_alu_ops();
        logic [31:0] prog [12];
        exp_t        a;
        prog = '{InsAdd, InsSub, 32'h40008093, 32'h4030D093, 32'h000003B7, 32'h00000397,
                 32'h00208063, 32'h0020E063, 32'h0020A023, 32'h000000EF, 32'h000100E7,
                 32'h0020C1B3};
        drive(1'b0, '0, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, prog[i], 1'b0, 1'b0);
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (rdy[k] !== mready[k]) begin
                    n_fail++;
                    $display("FAIL alu_ops.id_ready[%0d] i=%0d got %b want %b", k, i, rdy[k], mready[k]);
                end
            end
            tick();
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (act[k] !== mdl[k]) begin
                    n_fail++;
                    $display("FAIL alu_ops.ex[%0d] i=%0d got %h want %h", k, i, act[k], mdl[k]);
                end
            end
            a = act[0];
            if (i == 0) begin
                n_tests++;
                if (a.v !== 1'b1 || a.alu !== 4'd0 || a.rw !== 1'b1 || a.rd !== 5'd3) begin
                    n_fail++; $display("FAIL alu_ops.add got %h want v1 alu0 rw1 rd3", a);
                end
            end
            if (i == 1) begin
                n_tests++;
                if (a.alu !== 4'd1) begin
                    n_fail++; $display("FAIL alu_ops.sub alu got %0d want 1", a.alu);
                end
            end
        end
    endtask

    task automatic test_load_use();
        bit rdy_tbl [2][4];
        rdy_tbl = '{'{1, 0, 1, 1}, '{1, 0, 0, 1}};
        drive(1'b0, '0, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, (i == 0) ? InsLw5 : InsAdd6, 1'b0, 1'b0);
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (rdy[k] !== mready[k] || rdy[k] !== rdy_tbl[k][i]) begin
                    n_fail++;
                    $display("FAIL load_use.id_ready[%0d] c=%0d got %b want %b", k, i, rdy[k], rdy_tbl[k][i]);
                end
            end
            tick();
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (act[k] !== mdl[k]) begin
                    n_fail++;
                    $display("FAIL load_use.ex[%0d] c=%0d got %h want %h", k, i, act[k], mdl[k]);
                end
            end
        end
    endtask

    task automatic test_x0_load();
        exp_t a;
        drive(1'b0, '0, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, (i == 0) ? InsLw0 : InsAdd60, 1'b0, 1'b0);
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (rdy[k] !== 1'b1 || rdy[k] !== mready[k]) begin
                    n_fail++; $display("FAIL x0_load.id_ready[%0d] c=%0d got %b want 1", k, i, rdy[k]);
                end
            end
            tick();
            a = act[1];
            if (i == 0) begin
                n_tests++;
                if (a.rw !== 1'b0 || a.mr !== 1'b1 || a.v !== 1'b1) begin
                    n_fail++; $display("FAIL x0_load.lw got %h want rw0 mr1 v1", a);
                end
            end
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (act[k] !== mdl[k]) begin
                    n_fail++; $display("FAIL x0_load.ex[%0d] got %h want %h", k, act[k], mdl[k]);
                end
            end
        end
    endtask

    task automatic test_flush_stall();
        // lw; add (hazard, instance 1 enters its stall); add+flush; add
        drive(1'b0, '0, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, (i == 0) ? InsLw5 : InsAdd6, 1'b0, i == 2);
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (rdy[k] !== mready[k] || (i >= 2 && rdy[k] !== 1'b1)) begin
                    n_fail++;
                    $display("FAIL flush_stall.id_ready[%0d] c=%0d got %b want %b", k, i, rdy[k], mready[k]);
                end
            end
            tick();
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (act[k] !== mdl[k] || (i == 2 && act[k] !== 32'h0)) begin
                    n_fail++;
                    $display("FAIL flush_stall.ex[%0d] c=%0d got %h want %h", k, i, act[k], mdl[k]);
                end
            end
        end
    endtask

    task automatic test_hold();
        exp_t a;
        drive(1'b0, '0, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, (i == 0) ? InsAdd : InsSub, (i >= 1 && i <= 3), 1'b0);
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (rdy[k] !== mready[k] || rdy[k] !== !(i >= 1 && i <= 3)) begin
                    n_fail++; $display("FAIL hold.id_ready[%0d] c=%0d got %b want %b", k, i, rdy[k], mready[k]);
                end
            end
            tick();
            a = act[0];
            n_tests++;
            if (act[0] !== mdl[0] || act[1] !== mdl[1] || a.alu !== ((i == 4) ? 4'd1 : 4'd0) ||
                a.rd !== 5'd3) begin
                n_fail++; $display("FAIL hold.ex c=%0d got %h want %h", i, act[0], mdl[0]);
            end
        end
    endtask

    task automatic test_unknown_opcode();
        exp_t a;
        bit   exp_ill;
`ifdef CTRL_ILLEGAL_TRAP_EN
        exp_ill = 1'b1;
`else
        exp_ill = 1'b0;
`endif
        drive(1'b0, '0, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, (i == 0) ? InsUnk : InsAdd6, 1'b0, 1'b0);
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (rdy[k] !== 1'b1 || rdy[k] !== mready[k]) begin
                    n_fail++; $display("FAIL unknown.id_ready[%0d] c=%0d got %b want 1", k, i, rdy[k]);
                end
            end
            tick();
            a = act[0];
            if (i == 0) begin
                n_tests++;
                if (a.v !== 1'b1 || a.ill !== exp_ill ||
                    {a.rw, a.asrc, a.apc, a.mr, a.mw, a.m2r, a.br, a.jmp, a.alu} !== 12'h0) begin
                    n_fail++; $display("FAIL unknown.ex got %h want v1 ill%0b ctrl0", a, exp_ill);
                end
            end
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (act[k] !== mdl[k]) begin
                    n_fail++; $display("FAIL unknown.ex[%0d] c=%0d got %h want %h", k, i, act[k], mdl[k]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(0, 9) < 8, rand_instr(), $urandom_range(0, 9) == 0,
                  $urandom_range(0, 14) == 0);
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (rdy[k] !== mready[k]) begin
                    n_fail++;
                    $display("FAIL random.id_ready[%0d] c=%0d instr=%h got %b want %b", k, c, id_instr,
                             rdy[k], mready[k]);
                end
            end
            tick();
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (act[k] !== mdl[k]) begin
                    n_fail++;
                    $display("FAIL random.ex[%0d] c=%0d got %h want %h", k, c, act[k], mdl[k]);
                end
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            mdl[k]  = '0;
            left[k] = 0;
        end
        test_reset();
        test_alu_ops();
        test_load_use();
        test_x0_load();
        test_flush_stall();
        test_hold();
        test_unknown_opcode();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_ctrl_pipe.md
# id_ex_ctrl_pipe

Parametrised successor to the combinational main control decoder. Decodes a full RV32I instruction (opcode, funct3, funct7) into a widened control bundle with a direct ALU operation code, registers it into the ID/EX control pipeline register, and detects load-use hazards, inserting a configurable number of bubbles. Sits between the ID stage and the EX stage of the 5-stage pipeline; fetch/decode advance only when `id_ready` is high.

## Interface
Parameters:
- `ALU_CTRL_W`, 4: width of ALU operation code.
- `REG_ADDR_W`, 5: register index width.
- `LOAD_USE_BUBBLES`, 1: bubbles per load-use hazard (1 = MEM→EX forwarding present, 2 = no load forwarding); legal 1..3.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `id_valid` in 1: ID holds a valid instruction.
- `id_instr` in 32: instruction in ID.
- `id_ready` out 1: ID instruction accepted into ID/EX this cycle.
- `ex_hold` in 1: downstream stall; freeze ID/EX.
- `ex_flush` in 1: taken branch/jump resolved in EX; kill ID/EX contents and the ID instruction.
- `ex_valid` out 1: ID/EX holds a live instruction.
- `ex_reg_write`, `ex_alu_src`, `ex_alu_src_a_pc`, `ex_mem_read`, `ex_mem_write`, `ex_mem_to_reg`, `ex_branch`, `ex_jump` out 1 each: registered control bits.
- `ex_alu_ctrl` out `ALU_CTRL_W`: ALU operation.
- `ex_funct3` out 3: branch condition / access size.
- `ex_rd`, `ex_rs1`, `ex_rs2` out `REG_ADDR_W`: register indices.
- `ex_illegal` out 1: present only with `CTRL_ILLEGAL_TRAP_EN`.

## Operation
- Opcodes: R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111. Control bits match the previous decoder for the first seven; LUI: reg_write, alu_src, alu_ctrl=PASSB; AUIPC: reg_write, alu_src, alu_src_a_pc, ADD.
- `alu_ctrl`: ADD0 SUB1 SLL2 SLT3 SLTU4 XOR5 SRL6 SRA7 OR8 AND9 PASSB10. R-type uses funct3, instr[30] selects SUB/SRA. I-ALU: instr[30] honoured only for funct3=101 (SRAI); ADDI with bit30 set remains ADD. BRANCH: BEQ/BNE→SUB, BLT/BGE→SLT, BLTU/BGEU→SLTU. LOAD/STORE/JAL/JALR/AUIPC→ADD.
- `reg_write` forced 0 when rd=0.
- rs1 used by all except LUI/AUIPC/JAL; rs2 used by R, STORE, BRANCH.
- Hazard: `ex_valid & ex_mem_read & ex_rd!=0 & id_valid & ((uses_rs1 & rs1==ex_rd) | (uses_rs2 & rs2==ex_rd))`.
- FSM RUN/STALL with counter `cnt`. RUN + hazard: bubble into ID/EX, `id_ready`=0, cnt=LOAD_USE_BUBBLES-1, go STALL if cnt≠0. STALL: bubble, `id_ready`=0, decrement; return to RUN when cnt reaches 0.
- Priority per cycle: rst > ex_flush > ex_hold > hazard > normal advance.
- ex_flush: next ex_valid=0 and all ex_ control bits 0; FSM→RUN, cnt=0; `id_ready`=1 (wrong-path ID instruction dropped).
- ex_hold (no flush): ID/EX and FSM unchanged; `id_ready`=0.
- `id_valid`=0 in normal advance: bubble loaded, `id_ready`=1.
- Bubble = ex_valid 0 and every ex_ control bit 0; indices don't-care (cleared to 0).

## Timing
- Latency: ID → ID/EX outputs one cycle after the accepting edge.
- `id_ready` combinational from `id_instr`, `id_valid`, ID/EX state, FSM, `ex_hold`, `ex_flush`.
- Reset: all ex_ outputs 0, ex_valid 0, FSM RUN, cnt 0; `id_ready`=0 while rst high.
- Hazard with ex_hold simultaneously: hold wins; hazard re-evaluated next cycle.
- Flush during STALL: stall abandoned immediately.

## Configuration
- `CTRL_ILLEGAL_TRAP_EN` defined: unknown opcode, or R-type funct7 not in {0000000, 0100000}, decodes as bubble controls but with ex_valid=1 and `ex_illegal`=1 registered with it; cleared by bubble/flush/reset.
- Undefined: no `ex_illegal` port; unknown opcodes decode as NOP (ex_valid=1, all controls 0).

## Structure
- Shared package `ctrl_pkg`: opcode constants, ALU_CTRL encodings, control bundle typedef.
- One sub-module `ctrl_decode`: purely combinational instr → bundle plus uses_rs1/uses_rs2; top holds ID/EX register, hazard logic, FSM.

## Test plan
- `add x3,x1,x2` (0x002081B3) then `sub`: ex_alu_ctrl 0 then 1, reg_write 1, ex_rd 3, one cycle latency.
- `lw x5,0(x1)` then `add x6,x5,x2`, LOAD_USE_BUBBLES=1: one cycle id_ready=0, one bubble, add reaches EX at cycle 3; with =2, two bubbles.
- `lw x0,0(x1)` then `add x6,x0,x2`: no stall; reg_write 0 for lw.
- Load-use stall with ex_flush in the same cycle: ex_valid 0 next, FSM RUN, id_ready 1.
- ex_hold for 3 cycles with add in ID/EX: outputs stable, id_ready 0; released → next instruction one cycle later.
- Opcode 0x7F with macro defined: ex_valid 1, ex_illegal 1, all controls 0; macro undefined: NOP, no stall.
